// File: rtl/wide_add_pkg.sv
// Shared types and defaults for the word-serial wide adder.
// Imported by the sequencer and the word adder.
package wide_add_pkg;

    localparam int W_DEF     = 32;
    localparam int WORDS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/wide_add_seq_p_adder.sv
// W-bit combinational parallel-prefix (Kogge-Stone) adder.
// Carry-in is folded in after the group generate/propagate tree.
module p_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    localparam int LVL = (W > 1) ? $clog2(W) : 0;

    logic [W-1:0] p0;
    logic [W-1:0] gk;
    logic [W-1:0] pk;
    logic [W-1:0] gn;
    logic [W-1:0] pn;
    logic [W-1:0] c;

    always_comb begin
        p0 = a ^ b;
        gk = a & b;
        pk = p0;
        gn = '0;
        pn = '0;
        c  = '0;
        for (int l = 0; l < LVL; l++) begin
            gn = gk;
            pn = pk;
            for (int i = 0; i < W; i++) begin
                if (i >= (1 << l)) begin
                    gn[i] = gk[i] | (pk[i] & gk[i-(1<<l)]);
                    pn[i] = pk[i] & pk[i-(1<<l)];
                end
            end
            gk = gn;
            pk = pn;
        end
        // gk/pk[i] now span bits [i:0]
        c[0] = cin;
        for (int i = 1; i < W; i++) begin
            c[i] = gk[i-1] | (pk[i-1] & cin);
        end
    end

    assign s    = p0 ^ c;
    assign cout = gk[W-1] | (pk[W-1] & cin);

endmodule

// File: rtl/wide_add_seq.sv
// Word-serial wide adder: one W-bit word per clock, LSW first,
// carry chained through a register across words.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W*WORDS-1:0] in_a,
    input  logic [W*WORDS-1:0] in_b,
    input  logic               in_cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W*WORDS-1:0] out_sum,
    output logic               out_cout,
    output logic               busy
);

    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WORDS-1:0][W-1:0] opa_q, opa_d;
    logic [WORDS-1:0][W-1:0] opb_q, opb_d;
    logic [WORDS-1:0][W-1:0] sum_q, sum_d;
    logic carry_q, carry_d;
    logic cout_q, cout_d;

    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W-1:0] add_s;
    logic         add_co;

    assign add_a = opa_q[cnt_q];
    assign add_b = opb_q[cnt_q];

    p_adder #(
        .W(W)
    ) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_co)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    opa_d   = in_a;
                    opb_d   = in_b;
                    carry_d = in_cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy         = 1'b1;
                sum_d[cnt_q] = add_s;
                carry_d      = add_co;
                if (cnt_q == LAST) begin
                    cout_d  = add_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed and random bench for wide_add_seq (WORDS=4 and WORDS=1).
// Signals are driven and sampled 1ns after the rising edge.
module tb_wide_add_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, in_cin;
    logic [127:0] in_a, in_b;
    logic         out_valid, out_ready, out_cout, busy;
    logic [127:0] out_sum;

    logic        v1, r1, c1, ov1, or1, co1, b1;
    logic [31:0] a1, bb1, s1;

    int n_chk = 0;
    int n_pass = 0;

    wide_add_seq #(.W(32), .WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    wide_add_seq #(.W(32), .WORDS(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(v1), .in_ready(r1),
        .in_a(a1), .in_b(bb1), .in_cin(c1),
        .out_valid(ov1), .out_ready(or1),
        .out_sum(s1), .out_cout(co1), .busy(b1)
    );

    task automatic chk(input string tag, input logic [128:0] got,
                       input logic [128:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [127:0] a, input logic [127:0] b,
                          input logic c, input int stall,
                          input logic [127:0] es, input logic ec,
                          input string tag);
        int k;
        int lat;
        logic ok;
        logic [127:0] s0;
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin step; k++; end
        chk({tag, "_acc"}, in_ready, 1);
        step;
        in_valid = 1'b0; in_a = ~a; in_b = ~b; in_cin = ~c;
        lat = 0; ok = 1'b1;
        while (!out_valid && lat < 20) begin
            if (in_ready || !busy) ok = 1'b0;
            step;
            lat++;
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_run"}, ok, 1);
        s0 = out_sum; ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            in_valid = i[0];
            in_a = {4{$urandom}};
            step;
            if (!out_valid || out_sum !== s0 || in_ready) ok = 1'b0;
        end
        in_valid = 1'b0;
        if (stall > 0) chk({tag, "_hold"}, ok, 1);
        chk({tag, "_sum"}, {out_cout, out_sum}, {ec, es});
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        chk({tag, "_hs"}, {out_valid, in_ready, busy}, 3'b010);
    endtask

    task automatic run1(input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic [31:0] es,
                        input logic ec, input string tag);
        int lat;
        a1 = a; bb1 = b; c1 = c; v1 = 1'b1;
        chk({tag, "_acc"}, r1, 1);
        step;
        v1 = 1'b0; a1 = ~a;
        lat = 0;
        while (!ov1 && lat < 10) begin step; lat++; end
        chk({tag, "_lat"}, lat, 1);
        chk({tag, "_sum"}, {co1, s1}, {ec, es});
        or1 = 1'b1;
        step;
        or1 = 1'b0;
        chk({tag, "_hs"}, {ov1, r1}, 2'b01);
    endtask

    initial begin
        logic [127:0] ra, rb;
        logic [128:0] m;
        logic rc;
        logic ok;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0;
        v1 = 1'b0; or1 = 1'b0; a1 = '0; bb1 = '0; c1 = 1'b0;
        step; step;
        rst = 1'b0;
        chk("rst_ctl", {in_ready, out_valid, busy, out_cout}, 4'b1000);
        chk("rst_sum", out_sum, 0);

        run_op(128'h1, 128'h1, 1'b0, 0, 128'h2, 1'b0, "basic");
        run_op({128{1'b1}}, 128'h1, 1'b0, 0, 128'h0, 1'b1, "ripple");
        run_op({128{1'b1}}, {128{1'b1}}, 1'b1, 0,
               {128{1'b1}}, 1'b1, "ripple_cin");
        run_op({32{4'hA}}, {32{4'h5}}, 1'b0, 0,
               {128{1'b1}}, 1'b0, "alt");
        run_op({4{32'h12345678}}, {4{32'h87654321}}, 1'b1, 0,
               128'h99999999_99999999_99999999_9999999A, 1'b0, "mixed");
        run_op(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
               128'h1, 1'b0, 10,
               128'h0123_4567_89AB_CDEF_0011_2233_4455_6678, 1'b0, "bp");

        // abort in the second RUN cycle
        in_a = 128'h5; in_b = 128'h7; in_cin = 1'b0; in_valid = 1'b1;
        chk("abort_acc", in_ready, 1);
        step;
        in_valid = 1'b0;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("abort_ctl", {in_ready, out_valid, busy, out_cout}, 4'b1000);
        chk("abort_sum", out_sum, 0);
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step;
            if (out_valid || !in_ready) ok = 1'b0;
        end
        chk("abort_quiet", ok, 1);
        run_op(128'hFFFFFFFF_00000000_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 2,
               128'hFFFFFFFF_00000001_00000000_00000000, 1'b0, "post_abort");

        run1(32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, "w1_ripple");
        run1(32'h12345678, 32'h87654321, 1'b1, 32'h9999999A, 1'b0, "w1_mix");

        for (int n = 0; n < 500; n++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            if (n % 7 == 0) rb = ~ra;
            rc = 1'(($urandom) & 1);
            m = {1'b0, ra} + {1'b0, rb} + {128'b0, rc};
            run_op(ra, rb, rc, int'($urandom_range(0, 3)),
                   m[127:0], m[128], "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
- Multi-cycle sequencer that adds two WORDS×W-bit operands using one W-bit combinational prefix adder (p_adder), one word per clock, least-significant word first.
- Sits directly upstream of p_adder. It slices the operands, drives p_adder's a/b/cin each cycle, and consumes its s/cout, chaining the carry across words.
- Gives the datapath wide additions (default 128-bit) without widening the adder.
- Valid/ready handshake on both input and output sides.

Parameters:
- W, 32, word width; must equal p_adder width.
- WORDS, 4, number of words per operand; legal range ≥1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept an operand set.
- in_a  input  W*WORDS  operand A.
- in_b  input  W*WORDS  operand B.
- in_cin  input  1  carry into word 0.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W*WORDS  sum, modulo 2^(W*WORDS).
- out_cout  output  1  carry out of the most-significant word.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled on the rising edge.
- Reset values:
  - State IDLE, word counter 0.
  - in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0.
  - Carry register 0, operand registers 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_a, in_b and in_cin into the operand registers and carry register, clear the counter, and go to RUN.
- RUN (in_ready=0, busy=1):
  - Each cycle, drive p_adder with a=opA[cnt*W +: W], b=opB[cnt*W +: W], cin=carry register.
  - At the clock edge, write s into out_sum[cnt*W +: W] and cout into the carry register, then increment cnt.
  - When cnt==WORDS-1, the same edge copies cout to out_cout and moves to DONE.
  - Exactly WORDS cycles are spent in RUN.
- DONE:
  - out_valid=1. out_sum and out_cout are stable.
  - On out_valid&out_ready, go to IDLE. out_valid drops the next cycle.
  - No back-to-back accept in the cycle the result is taken: in_ready rises one cycle after the output handshake.
- Latency: accept edge at cycle 0, out_valid high from cycle WORDS. Minimum throughput is one operation per WORDS+2 cycles.
- Backpressure: out_ready low holds DONE indefinitely with outputs unchanged. in_valid is ignored outside IDLE.
- out_sum and out_cout are registered and change only in RUN. Partial-sum words are visible during RUN but are not valid until out_valid.
- WORDS=1: a single RUN cycle; behaviour equals one registered p_adder operation.
- Counter width is $clog2(WORDS), minimum 1 bit. There is no counter wrap: the FSM leaves RUN at WORDS-1.
- Reset mid-operation (RUN or DONE): abort, restore all reset values, discard the partial result. No out_valid is produced for the aborted operation.
- Input operands may change after acceptance without affecting the result.

Decomposition:
- Shared package wide_add_pkg holds:
  - The state enum type (IDLE/RUN/DONE).
  - The default constants W_DEF=32 and WORDS_DEF=4.
- One sub-module: the existing p_adder, instantiated once, purely combinational.
- The sequencer contains the FSM, counter, operand/carry registers and the result register.

Test Plan:
- Basic add: WORDS=4, A=0x0000_0000_0000_0000_0000_0000_0000_0001, B=1, cin=0. Require sum=0x…0002, cout=0, out_valid exactly 4 cycles after the accept edge, in_ready=0 throughout.
- Full carry ripple across words: A=all ones (128'hFFFF…FFFF), B=1, cin=0. Require sum=0, cout=1. Also cin=1 with A=B=all ones: require sum=all ones except bit0 set (128'hFFFF…FFFF), cout=1.
- Alternating patterns: A=128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA, B=128'h55555555_…, cin=0. Require sum=all ones, cout=0. Mixed case: A=128'h12345678_…_12345678, B=128'h87654321_…, cin=1. Require per-word 0x9999999A at word 0, 0x99999999 at words 1–3, cout=0.
- Backpressure and handshake: hold out_ready=0 for 10 cycles in DONE. Require out_valid and out_sum stable, in_ready=0, and in_valid pulses ignored. Then out_ready=1 for 1 cycle: require out_valid=0 and in_ready=1 on the following cycle.
- Reset mid-run: assert rst in the 2nd RUN cycle. Require all outputs at reset values on the next cycle, no out_valid afterwards, and a new operation accepted and computed correctly.
- Randomised sanity plus WORDS=1 build: 500 random operand sets with random out_ready stalls, compared against a behavioural (W*WORDS+1)-bit sum. For WORDS=1, require out_valid 1 cycle after accept.
